// File: rtl/uart_defines.sv
// uart_defines: shared constants and arbiter state encodings for the
// UART transmit path (used alongside uart_transmit_fsm_defines).
package uart_defines;

  localparam int UART_DATA_W     = 8;
  localparam int ARB_MAX_BURST   = 16;
  localparam int ARB_ACK_TIMEOUT = 64;
  localparam int ARB_BURST_W     = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// valid: request vector; ptr: search start; winner/any_valid: result.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] winner,
  output logic               any_valid
);

  logic [GRANT_W-1:0] idx;

  // Walk from the farthest slot back to ptr so the nearest valid
  // index at or after ptr (with wrap) is the last one written.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = GRANT_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) winner = idx;
    end
    any_valid = |valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART
// transmitter among NUM_REQ byte producers.
// Ports: req_valid/req_data/req_last/req_ready per producer;
// tx_send/tx_data/tx_ready to the transmitter; grant_id, busy,
// sticky err_timeout (cleared by err_clr) for status.
module uart_tx_arbiter
  import uart_defines::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GRANT_W     = 2,
  parameter int DATA_W      = UART_DATA_W,
  parameter int MAX_BURST   = ARB_MAX_BURST,
  parameter int ACK_TIMEOUT = ARB_ACK_TIMEOUT,
  parameter int TO_W        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_send,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      err_timeout,
  input  logic                      err_clr
);

  arb_state_e state_q, state_d;

  logic [GRANT_W-1:0]     rr_q, grant_q, pick, nxt_rr;
  logic                   any_valid;
  logic [ARB_BURST_W-1:0] burst_q;
  logic [TO_W-1:0]        to_q;
  logic [DATA_W-1:0]      data_q;
  logic                   last_q, err_q;
  logic                   gnt_valid, to_hit, pkt_done, to_evt;
  logic [DATA_W-1:0]      data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .GRANT_W(GRANT_W)
  ) u_pick (
    .valid    (req_valid),
    .ptr      (rr_q),
    .winner   (pick),
    .any_valid(any_valid)
  );

  assign gnt_valid = req_valid[grant_q];
  assign to_hit    = (to_q == TO_W'(ACK_TIMEOUT - 1));
  assign to_evt    = (state_q == WAIT_ACK) && tx_ready && to_hit;
  assign pkt_done  = last_q ||
                     (burst_q == ARB_BURST_W'(MAX_BURST));
  assign nxt_rr    = (grant_q == GRANT_W'(NUM_REQ - 1)) ?
                     '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (tx_ready && any_valid) state_d = LATCH;
      LATCH:
        state_d = gnt_valid ? SEND : IDLE;
      SEND:
        state_d = WAIT_ACK;
      WAIT_ACK:
        if (!tx_ready)   state_d = WAIT_DONE;
        else if (to_hit) state_d = IDLE;
      WAIT_DONE:
        if (tx_ready) state_d = pkt_done ? IDLE : LATCH;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    tx_send   = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      LATCH:   req_ready[grant_q] = 1'b1;
      SEND:    tx_send = 1'b1;
      default: ;
    endcase
  end

  // rr_q only moves on release, so a withdrawn or aborted grant
  // still hands priority to the next requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      burst_q <= '0;
      to_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE:
          if (tx_ready && any_valid) begin
            grant_q <= pick;
            burst_q <= '0;
          end
        LATCH:
          if (gnt_valid) begin
            data_q  <= data_arr[grant_q];
            last_q  <= req_last[grant_q];
            burst_q <= burst_q + 1'b1;
          end else begin
            rr_q <= nxt_rr;
          end
        SEND:
          to_q <= '0;
        WAIT_ACK:
          if (tx_ready) begin
            if (to_hit) rr_q <= nxt_rr;
            else        to_q <= to_q + 1'b1;
          end
        WAIT_DONE:
          if (tx_ready && pkt_done) rr_q <= nxt_rr;
        default: ;
      endcase
    end
  end

  // A timeout in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (to_evt)  err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// Instance 0 uses MAX_BURST=16, instance 1 uses MAX_BURST=2.
module tb_uart_tx_arbiter;
  import uart_defines::*;

  localparam int N    = 4;
  localparam int GW   = 2;
  localparam int DW   = UART_DATA_W;
  localparam int TOUT = ARB_ACK_TIMEOUT;
  localparam int ND   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic ignore_send = 1'b0;

  logic [N-1:0]    req_valid [ND];
  logic [N*DW-1:0] req_data [ND];
  logic [N-1:0]    req_last [ND];
  logic [N-1:0]    req_ready [ND];
  logic            tx_send [ND];
  logic [DW-1:0]   tx_data [ND];
  logic            tx_ready [ND];
  logic [GW-1:0]   grant_id [ND];
  logic            busy [ND];
  logic            err_timeout [ND];

  logic [DW:0]      pq [ND][N][$];
  logic [GW+DW-1:0] exp_q [ND][$];
  int bcnt [ND];
  int rdy_cnt [ND][N];
  int send_cnt [ND];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    uart_tx_arbiter #(
      .NUM_REQ(N), .GRANT_W(GW), .DATA_W(DW),
      .MAX_BURST(d == 0 ? 16 : 2),
      .ACK_TIMEOUT(TOUT), .TO_W(7)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[d]), .req_data(req_data[d]),
      .req_last(req_last[d]), .req_ready(req_ready[d]),
      .tx_send(tx_send[d]), .tx_data(tx_data[d]),
      .tx_ready(tx_ready[d]), .grant_id(grant_id[d]),
      .busy(busy[d]), .err_timeout(err_timeout[d]),
      .err_clr(err_clr)
    );
  end

  // producers: pop on handshake, present head of queue
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < N; i++)
        if (rst_n && req_valid[d][i] && req_ready[d][i]
            && pq[d][i].size() > 0)
          void'(pq[d][i].pop_front());
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < N; i++) begin
        e = '0;
        if (pq[d][i].size() > 0) e = pq[d][i][0];
        req_valid[d][i] = (pq[d][i].size() > 0);
        req_data[d][i*DW +: DW] = e[DW-1:0];
        req_last[d][i] = e[DW];
      end
  end

  // transmitter: busy for 5 clocks after a send, unless ignoring
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (tx_send[d] && !(d == 0 && ignore_send)) bcnt[d] = 5;
      else if (bcnt[d] > 0) bcnt[d] = bcnt[d] - 1;
    end
    #1;
    for (int d = 0; d < ND; d++) tx_ready[d] = (bcnt[d] == 0);
  end

  // monitor: compare each transmitted byte against the scoreboard
  always @(negedge clk) begin
    logic [GW+DW-1:0] ex;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < N; i++)
        if (req_ready[d][i]) rdy_cnt[d][i] = rdy_cnt[d][i] + 1;
      if (tx_send[d]) begin
        send_cnt[d] = send_cnt[d] + 1;
        n_chk = n_chk + 1;
        if (exp_q[d].size() == 0) begin
          $display("FAIL sb%0d extra byte: got grant %0d data %h, want none",
                   d, grant_id[d], tx_data[d]);
        end else begin
          ex = exp_q[d].pop_front();
          if ({grant_id[d], tx_data[d]} == ex) n_pass = n_pass + 1;
          else $display("FAIL sb%0d byte: got grant %0d data %h, want grant %0d data %h",
                        d, grant_id[d], tx_data[d], ex[GW+DW-1:DW], ex[DW-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic push(input int d, input int i,
                      input logic [DW-1:0] data, input logic last);
    pq[d][i].push_back({last, data});
  endtask

  task automatic expect_tx(input int d, input int g,
                           input logic [DW-1:0] data);
    logic [GW-1:0] gg;
    gg = g[GW-1:0];
    exp_q[d].push_back({gg, data});
  endtask

  task automatic wait_done(input int d, input string name);
    int t;
    bit ok;
    t = 0;
    ok = 0;
    while (t < 2000 && !ok) begin
      @(negedge clk);
      t++;
      ok = !busy[d] && tx_ready[d] && exp_q[d].size() == 0;
      for (int i = 0; i < N; i++)
        if (pq[d][i].size() != 0) ok = 0;
    end
    chk({name, " drained"}, 32'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, r0, s0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst busy", 32'(busy[0]), 0);
    chk("rst grant_id", 32'(grant_id[0]), 0);
    chk("rst tx_data", 32'(tx_data[0]), 0);
    chk("rst req_ready", 32'(req_ready[0]), 0);
    chk("rst tx_send", 32'(tx_send[0]), 0);
    chk("rst err", 32'(err_timeout[0]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 1: single byte from requester 2
    r0 = rdy_cnt[0][2];
    s0 = send_cnt[0];
    push(0, 2, 8'hA5, 1'b1);
    expect_tx(0, 2, 8'hA5);
    wait_done(0, "t1");
    chk("t1 req_ready cycles", 32'(rdy_cnt[0][2] - r0), 1);
    chk("t1 tx_send pulses", 32'(send_cnt[0] - s0), 1);
    chk("t1 grant_id", 32'(grant_id[0]), 2);
    chk("t1 tx_data held", 32'(tx_data[0]), 32'hA5);

    // 2: all valid, pointer at 3 -> 3,0,1,2
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) push(0, i, 8'(8'h30 + i), 1'b1);
    expect_tx(0, 3, 8'h33);
    expect_tx(0, 0, 8'h30);
    expect_tx(0, 1, 8'h31);
    expect_tx(0, 2, 8'h32);
    wait_done(0, "t2");

    // 3: packet lock on requester 1 while 0 waits
    @(posedge clk);
    #2;
    push(0, 1, 8'h11, 1'b0);
    push(0, 1, 8'h12, 1'b0);
    push(0, 1, 8'h13, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2;
    push(0, 0, 8'h0A, 1'b1);
    expect_tx(0, 1, 8'h11);
    expect_tx(0, 1, 8'h12);
    expect_tx(0, 1, 8'h13);
    expect_tx(0, 0, 8'h0A);
    wait_done(0, "t3");

    // 4: burst cap of 2 on instance 1
    r0 = rdy_cnt[1][0];
    for (int i = 0; i < 5; i++) push(1, 0, 8'(8'h40 + i), 1'b0);
    push(1, 3, 8'h50, 1'b1);
    push(1, 3, 8'h51, 1'b1);
    expect_tx(1, 0, 8'h40);
    expect_tx(1, 0, 8'h41);
    expect_tx(1, 3, 8'h50);
    expect_tx(1, 0, 8'h42);
    expect_tx(1, 0, 8'h43);
    expect_tx(1, 3, 8'h51);
    expect_tx(1, 0, 8'h44);
    wait_done(1, "t4");
    chk("t4 req_ready[0] incl withdraw", 32'(rdy_cnt[1][0] - r0), 6);

    // 5: transmitter ignores send
    ignore_send = 1'b1;
    push(0, 0, 8'h66, 1'b1);
    expect_tx(0, 0, 8'h66);
    t = 0;
    while (!tx_send[0] && t < 200) begin @(negedge clk); t++; end
    chk("t5 send seen", 32'(tx_send[0]), 1);
    t = 0;
    while (!err_timeout[0] && t < 200) begin @(negedge clk); t++; end
    chk("t5 err delay", 32'(t >= TOUT && t <= TOUT + 1), 1);
    chk("t5 idle at err", 32'(busy[0]), 0);
    @(posedge clk);
    #2;
    err_clr = 1'b1;
    @(posedge clk);
    #2;
    err_clr = 1'b0;
    chk("t5 err cleared", 32'(err_timeout[0]), 0);
    err_clr = 1'b1;
    push(0, 0, 8'h67, 1'b1);
    expect_tx(0, 0, 8'h67);
    t = 0;
    while (!err_timeout[0] && t < 300) begin @(negedge clk); t++; end
    err_clr = 1'b0;
    chk("t5 set beats clr", 32'(err_timeout[0]), 1);
    repeat (3) @(negedge clk);
    chk("t5 err sticky", 32'(err_timeout[0]), 1);
    ignore_send = 1'b0;

    // 6: reset in WAIT_DONE
    @(posedge clk);
    #2;
    push(0, 2, 8'h77, 1'b1);
    expect_tx(0, 2, 8'h77);
    t = 0;
    while (!tx_send[0] && t < 200) begin @(negedge clk); t++; end
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("t6 busy before reset", 32'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 tx_send in reset", 32'(tx_send[0]), 0);
    chk("t6 req_ready in reset", 32'(req_ready[0]), 0);
    chk("t6 busy in reset", 32'(busy[0]), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(0, 1, 8'h81, 1'b1);
    push(0, 0, 8'h80, 1'b1);
    expect_tx(0, 0, 8'h80);
    expect_tx(0, 1, 8'h81);
    wait_done(0, "t6");
    chk("t6 err after reset", 32'(err_timeout[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_transmit instance (9600 baud, 8N1) among NUM_REQ on-chip byte producers. Each producer offers bytes with a valid/ready handshake. The arbiter picks a producer by round-robin and locks the grant for a multi-byte packet until the producer flags its last byte. It sequences the transmitter's send/ready handshake one byte at a time and flags a transmitter that fails to respond.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GRANT_W, 2, width of grant index; must equal clog2(NUM_REQ)
DATA_W, 8, byte width; matches transmitter line_length
MAX_BURST, 16, max bytes per grant before forced release (1..255)
ACK_TIMEOUT, 64, clocks allowed for tx_ready to fall after tx_send
TO_W, 7, timeout counter width; must hold ACK_TIMEOUT

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  per-requester byte, requester i at bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  byte is last of packet
req_ready  out  NUM_REQ  one-hot; byte accepted when valid&ready same cycle
tx_send  out  1  send strobe to transmitter
tx_data  out  DATA_W  byte to transmitter
tx_ready  in  1  transmitter idle flag
grant_id  out  GRANT_W  current/last granted requester
busy  out  1  high in any state but IDLE
err_timeout  out  1  sticky; transmitter ignored tx_send
err_clr  in  1  clears err_timeout

Behaviour:
- Reset values: state IDLE, rr pointer 0, grant_id 0, tx_data 0, burst count 0, err_timeout 0. All other outputs decode to 0 in IDLE. Async assertion mid-operation drops tx_send at once and abandons the in-flight byte; no req_ready is issued.
- IDLE: if tx_ready=1 and any req_valid, the winner is the first valid index at or after the rr pointer, searching upward with wrap from NUM_REQ-1 to 0. Set grant_id to the winner, burst=0, go to LATCH. Otherwise stay in IDLE.
- LATCH: req_ready[grant_id]=1 for exactly this cycle, decoded from state.
  - If req_valid[grant_id]=1: register tx_data and last_q, burst+=1, go to SEND.
  - If req_valid[grant_id]=0 (requester withdrew or has no next byte): release, rr pointer = grant_id+1 mod NUM_REQ, go to IDLE.
- SEND: tx_send=1 for exactly one clock, timeout counter=0, go to WAIT_ACK.
- WAIT_ACK: tx_ready=0 -> WAIT_DONE. Otherwise the counter increments. At count ACK_TIMEOUT-1: set err_timeout, release as above, go to IDLE.
- WAIT_DONE: wait for tx_ready=1. Then:
  - if last_q=1 or burst=MAX_BURST: release, rr pointer advances, go to IDLE.
  - otherwise go to LATCH with the same grant.
- tx_data stays stable from the LATCH capture until the next LATCH capture, because the transmitter samples data on the falling edge while READY.
- Per-byte latency: IDLE->LATCH 1 clk, LATCH->SEND 1 clk, SEND->tx_send seen at next falling edge. Arbiter overhead is 3 clocks plus the 10 transmitter bit times.
- err_clr and a new timeout in the same cycle: set wins.
- req_valid on non-granted requesters is ignored while locked. No req_ready is ever asserted outside LATCH.
- tx_ready=0 in IDLE (transmitter busy from another source or still settling): no grant is made.

Decomposition:
- Shared package uart_defines (alongside uart_transmit_fsm_defines) holds:
  - arbiter state encodings IDLE/LATCH/SEND/WAIT_ACK/WAIT_DONE, 3-bit;
  - UART_DATA_W=8;
  - default MAX_BURST and ACK_TIMEOUT constants.
- One sub-module, uart_rr_pick: combinational round-robin picker. Inputs: valid vector, pointer. Outputs: winner index and any_valid. Unit-testable alone.

Test Plan:
1. Single byte: reset, req_valid[2]=1, data 8'hA5, last=1. Required: req_ready[2] high for 1 clk, tx_send one pulse, tx_data=8'hA5, grant_id=2, and after tx_ready returns, busy=0 with pointer 3.
2. Round-robin wrap: all 4 valid, last=1 each, pointer 3. Grant order must be 3,0,1,2, one byte each, no requester granted twice before all are served.
3. Packet lock: req 1 sends 3 bytes (last on the third) while req 0 is valid throughout. All 3 bytes from req 1 go out back-to-back, then req 0 is granted.
4. Burst cap: MAX_BURST=2, req 0 streams 5 bytes with last=0 and req 3 is valid. Grants must run 0,0,3,...,0, with forced release after every 2 bytes.
5. Timeout: transmitter model holds tx_ready=1 and ignores send. err_timeout sets ACK_TIMEOUT clocks after tx_send and the FSM returns to IDLE; err_clr clears it, and err_clr in the same cycle as a second timeout leaves it set.
6. Reset mid-byte: assert rst_n=0 in WAIT_DONE. tx_send, req_ready and busy are 0 immediately; after release the pointer is 0 and the next grant follows normally.
